// File: rtl/timer_counter_pkg.sv
// timer_counter shared definitions:
// register map, FSM states, CTRL layout.
package tc_defs;
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  localparam int TC_CTRL_EN      = 0;
  localparam int TC_CTRL_MODE_LO = 1;
  localparam int TC_CTRL_MODE_HI = 2;
  localparam int TC_CTRL_IM      = 3;

  localparam logic [1:0] TC_MODE_ONESHOT = 2'd0;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'd1;
endpackage

// File: rtl/timer_counter_if.sv
// timer_counter register bus: word strobe,
// register select, read data and interrupt.
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr, we, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, we, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter with
// one-shot / auto-reload interrupt.
module timer_counter
  import tc_defs::*;
(
  input logic      clk,
  input logic      reset,
  timer_counter_if.slave bus
);
  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        en;
  logic        oneshot;
  logic        ctrl_wr;
  logic        preset_wr;

  assign en = ctrl_q[TC_CTRL_EN];
  assign oneshot =
    ctrl_q[TC_CTRL_MODE_HI:TC_CTRL_MODE_LO]
    != TC_MODE_RELOAD;
  assign ctrl_wr = bus.we && (bus.addr == TC_CTRL);
  assign preset_wr = bus.we && (bus.addr == TC_PRESET);

  always_ff @(posedge clk) begin
    if (reset) state_q <= TC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TC_IDLE: if (en) state_d = TC_LOAD;
      TC_LOAD: state_d = TC_CNT;
      TC_CNT: begin
        if (!en)
          state_d = TC_IDLE;
        else if (count_q <= 32'd1)
          state_d = TC_INT;
      end
      TC_INT:  state_d = TC_IDLE;
      default: state_d = TC_IDLE;
    endcase
  end

  // Bus writes are applied last so a CTRL
  // write beats the one-shot Enable clear.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    unique case (state_q)
      TC_LOAD: count_d = preset_q;
      TC_CNT: begin
        if (en) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = '0;
            flag_d  = 1'b1;
          end
        end
      end
      TC_INT: begin
        if (oneshot) ctrl_d[TC_CTRL_EN] = 1'b0;
        else         flag_d = 1'b0;
      end
      default: ;
    endcase
    if (ctrl_wr) begin
      ctrl_d = bus.wdata[3:0];
      flag_d = 1'b0;
    end
    if (preset_wr) begin
      preset_d = bus.wdata;
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      TC_CTRL:   bus.rdata = {28'd0, ctrl_q};
      TC_PRESET: bus.rdata = preset_q;
      TC_COUNT:  bus.rdata = count_q;
      default:   bus.rdata = '0;
    endcase
  end

  assign bus.irq = ctrl_q[TC_CTRL_IM] & flag_q;
endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter with interrupt output, placed directly downstream of the pipelined CPU's data-memory port through the system bridge. The bridge decodes the CPU's store/load address and word-wide byte enable into a word write strobe and a register select for this block. The block's interrupt output feeds one bit of the CPU's `HWInt[5:0]` input. Two instances (TC0, TC1) are used in the system.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  2  word offset (CPU address bits [3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
- `we`  in  1  word write strobe; the bridge asserts it only for in-range `sw` (byte enable 4'b1111)
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational from `addr`
- `irq`  out  1  interrupt request to `HWInt`; registered

## Operation
Registers:
- CTRL[0] Enable, CTRL[2:1] Mode, CTRL[3] IM (interrupt mask). Bits [31:4] are not stored and read 0.
- PRESET is a 32-bit reload value.
- COUNT is 32 bits and read-only; writes to it are ignored.
- Offset 3 reads 0; writes to it are ignored.

`irq` = IM & irq_flag.

State machine (2-bit state: IDLE, LOAD, CNT, INT):
- IDLE: if Enable, go to LOAD. COUNT holds.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - If !Enable, go to IDLE; COUNT holds.
  - Else if COUNT > 1, COUNT <= COUNT-1.
  - Else (COUNT is 0 or 1), COUNT <= 0, irq_flag <= 1, go to INT.
- INT, Mode 0 (one-shot): Enable <= 0; go to IDLE; irq_flag stays set.
- INT, Mode 1 (auto-reload): irq_flag <= 0; go to IDLE. Enable stays set, so the counter reloads.
- INT, Mode 2/3: treated as Mode 0.

Write side effects:
- A write to CTRL or PRESET clears irq_flag.
- A CTRL write takes effect at the write edge. The state machine evaluates pre-edge register values.
- If a CTRL write coincides with the INT-state Enable clear, the written value wins.
- A PRESET write during CNT does not disturb COUNT. The new value is used at the next LOAD.
- Clearing Enable mid-count freezes COUNT. Setting Enable again reloads from PRESET; there is no resume.

Arithmetic: unsigned 32-bit. COUNT never underflows.

## Timing
Reset values: state IDLE, CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, `irq` = 0. `rdata` follows `addr` (offset 0 reads 0).

Latency from a CTRL write with Enable=1 at edge W:
- Edge W+1: state = LOAD.
- Edge W+2: COUNT = PRESET, state = CNT.
- Edge W+2+k: COUNT = PRESET−k, for k < PRESET.
- Edge W+2+max(PRESET,1): COUNT = 0, `irq` rises (if IM=1).
- PRESET = 0 and PRESET = 1 behave identically.

Mode 1: `irq` is high for exactly 1 cycle. The interrupt period is max(PRESET,1)+3 cycles.

Mode 0: `irq` stays high until the next CTRL or PRESET write or reset.

Reset mid-count: returns everything to reset values at that edge.

`rdata` reflects register state after the most recent edge (read-after-write sees the new value the next cycle).

## Structure
- Shared header `tc_defs`, containing:
  - register offsets `TC_CTRL`, `TC_PRESET`, `TC_COUNT`
  - state encodings `TC_IDLE`, `TC_LOAD`, `TC_CNT`, `TC_INT`
  - CTRL bit positions
  - mode values `TC_MODE_ONESHOT`, `TC_MODE_RELOAD`
- Single flat module; no sub-module.
- The bridge instantiates two copies and wires `irq` to `HWInt[2]` and `HWInt[3]`.

## Test plan
- Reset for 2 cycles, then read all offsets -> CTRL/PRESET/COUNT/reserved all read 0; `irq` = 0.
- PRESET=5, then CTRL=4'b1001 (IM, Mode 0, Enable) at edge W -> COUNT 5,4,3,2,1 on edges W+2..W+6; `irq` rises at W+7 and stays high; CTRL[0] reads 0 from W+8; writing CTRL=0 drops `irq` next cycle.
- PRESET=3, CTRL=4'b1011 (Mode 1) -> `irq` is a 1-cycle pulse every 6 cycles, first pulse at W+5; COUNT reloads to 3 each period.
- Mode 1 running with PRESET=10; write PRESET=2 mid-count -> the current period completes from 10; the following period uses 2.
- Enable cleared while COUNT=7 -> COUNT freezes at 7, no `irq`; Enable re-set -> COUNT reloads to PRESET two edges later.
- Write COUNT=0x1234 and offset 3 while counting; assert reset while COUNT=4 -> both writes are ignored; reset returns all registers to 0 at that edge.
